// File: rtl/sys_defs_pkg.sv
// Shared processor definitions: CDB payload, CDB source ids and arbiter sizing.
package sys_defs;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ROB_TAG_W   = 5;
  localparam int unsigned N_CDB_SRC   = 3;
  localparam int unsigned CDB_Q_DEPTH = 2;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      value;
    logic [ROB_TAG_W-1:0] rob_tag;
  } CDB_DATA;

  typedef enum logic [1:0] {
    CDB_SRC_ALU  = 2'd0,
    CDB_SRC_ADDR = 2'd1,
    CDB_SRC_LOAD = 2'd2
  } CDB_SRC;

endpackage

// File: rtl/cdb_src_queue.sv
// Single-source FIFO of CDB results; caller guarantees no push when full
// and no pop when empty.
module cdb_src_queue
  import sys_defs::*;
#(
  parameter int unsigned Q_DEPTH = CDB_Q_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         squash,
  input  logic                         push,
  input  CDB_DATA                      push_data,
  input  logic                         pop,
  output CDB_DATA                      head,
  output logic [$clog2(Q_DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);
  localparam int unsigned PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

  CDB_DATA          mem [Q_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(Q_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy state; squash empties the queue outright.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (squash) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !squash) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin scheduler sharing the Common Data Bus between result producers,
// with per-source queues and a registered broadcast.
module cdb_arbiter
  import sys_defs::*;
#(
  parameter int unsigned N_SRC   = N_CDB_SRC,
  parameter int unsigned Q_DEPTH = CDB_Q_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     squash,
  input  CDB_DATA                  src_data [N_SRC],
  output logic [N_SRC-1:0]         src_ready,
  output CDB_DATA                  cdb_out,
  output logic [$clog2(N_SRC)-1:0] cdb_src_id,
  output logic                     all_empty
);

  localparam int unsigned SRC_W = $clog2(N_SRC);
  localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);

  logic [CNT_W-1:0] count [N_SRC];
  CDB_DATA          head  [N_SRC];
  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] pop;
  logic [N_SRC-1:0] req;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_valid;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign req[i]       = (count[i] != '0);
    assign src_ready[i] = (count[i] < CNT_W'(Q_DEPTH));
    assign push[i]      = src_data[i].valid & src_ready[i];
    assign pop[i]       = grant_valid & (grant_idx == SRC_W'(i));

    cdb_src_queue #(
      .Q_DEPTH (Q_DEPTH)
    ) u_queue (
      .clock     (clock),
      .reset_n   (reset_n),
      .squash    (squash),
      .push      (push[i]),
      .push_data (src_data[i]),
      .pop       (pop[i]),
      .head      (head[i]),
      .count     (count[i])
    );
  end

  assign all_empty = ~|req;

  // First non-empty source at or after rr_ptr, wrapping.
  always_comb begin : pick
    int unsigned idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx = (32'(rr_ptr) + k) % N_SRC;
      if (!grant_valid && req[SRC_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(idx);
      end
    end
  end

  // Broadcast register; payload and source id hold when idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cdb_out    <= '0;
      cdb_src_id <= '0;
      rr_ptr     <= '0;
    end else if (squash) begin
      cdb_out.valid <= 1'b0;
      rr_ptr        <= '0;
    end else if (grant_valid) begin
      cdb_out    <= '{valid:   1'b1,
                      value:   head[grant_idx].value,
                      rob_tag: head[grant_idx].rob_tag};
      cdb_src_id <= grant_idx;
      rr_ptr     <= (grant_idx == SRC_W'(N_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
    end else begin
      cdb_out.valid <= 1'b0;
    end
  end

endmodule
